ym_timer_bank: RTL and testbench

- Parametrised multi-channel successor to the single YM2610-style timer. It generalises channel count, counter width and prescaler width.
- Adds one-shot/auto-reload mode per channel, per-channel IRQ enable and a combined active-low interrupt.
- Sits in the Audio YM block beside the register file. Advances only on TICK_144 clock-enable pulses.

---
 rtl/ym_timer_bank.sv | 99 +++++++++
 tb/tb_ym_timer_bank.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_timer_bank.sv
// ym_timer_bank: multi-channel YM2610-style timer bank (prescaler + loadable counter, one-shot or
// auto-reload, sticky flags, combined active-low IRQ). Define YM_TIMER_CSM_EN to add the CSM key-on pulse.
module ym_timer_bank #(
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 10,
  parameter int PRESCALE_W = 4
) (
  input  logic                          CLK,
  input  logic                          nRESET,
  input  logic                          TICK_144,
  input  logic [CHANNELS*CNT_WIDTH-1:0] LOAD_VALUE,
  input  logic [CHANNELS-1:0]           LOAD,
  input  logic [CHANNELS-1:0]           SET_RUN,
  input  logic [CHANNELS-1:0]           CLR_RUN,
  input  logic [CHANNELS-1:0]           CLR_FLAG,
  input  logic [CHANNELS-1:0]           ONESHOT,
  input  logic [CHANNELS-1:0]           IRQ_EN,
  output logic [CHANNELS-1:0]           RUN,
  output logic [CHANNELS-1:0]           OVF,
  output logic [CHANNELS-1:0]           OVF_FLAG,
`ifdef YM_TIMER_CSM_EN
  input  logic                          CSM_MODE,
  output logic                          CSM_KEYON,
`endif
  output logic                          nIRQ
);

  localparam int SW = CNT_WIDTH + PRESCALE_W;

  logic [CHANNELS-1:0] w_wrap;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      logic [SW-1:0] r_state;
      logic          r_run;
      logic          r_ovf;
      logic          r_flag;
      logic [SW-1:0] w_reload;

      // Reload value is sampled live, so a mid-count change only affects the next reload.
      assign w_reload  = {LOAD_VALUE[g*CNT_WIDTH +: CNT_WIDTH], {PRESCALE_W{1'b0}}};
      assign w_wrap[g] = TICK_144 & r_run & ~LOAD[g] & (&r_state);

      always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
          r_state <= '0;
          r_run   <= 1'b0;
          r_ovf   <= 1'b0;
          r_flag  <= 1'b0;
        end else begin
          if (LOAD[g] || w_wrap[g]) begin
            r_state <= w_reload;
          end else if (TICK_144 && r_run) begin
            r_state <= r_state + SW'(1);
          end

          if (CLR_RUN[g]) begin
            r_run <= 1'b0;
          end else if (LOAD[g] || SET_RUN[g]) begin
            r_run <= 1'b1;
          end else if (w_wrap[g] && ONESHOT[g]) begin
            r_run <= 1'b0;
          end

          r_ovf <= w_wrap[g];

          // A new overflow beats a coincident clear so no event is lost.
          if (w_wrap[g]) begin
            r_flag <= 1'b1;
          end else if (CLR_FLAG[g]) begin
            r_flag <= 1'b0;
          end
        end
      end

      assign RUN[g]      = r_run;
      assign OVF[g]      = r_ovf;
      assign OVF_FLAG[g] = r_flag;
    end
  endgenerate

  assign nIRQ = ~|(OVF_FLAG & IRQ_EN);

`ifdef YM_TIMER_CSM_EN
  logic r_csm_keyon;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_csm_keyon <= 1'b0;
    end else begin
      r_csm_keyon <= w_wrap[0] & CSM_MODE;
    end
  end

  assign CSM_KEYON = r_csm_keyon;
`endif

endmodule

// File: tb/tb_ym_timer_bank.sv
// Self-checking bench for ym_timer_bank: strobe vector table, hand-written timing sequences and a
// randomized run against a countdown reference model.
module tb_ym_timer_bank;
  localparam int CH = 2;
  localparam int CW = 10;
  localparam int PW = 4;
  localparam int CNT_N = 1 << CW;
  localparam int PRE_N = 1 << PW;

  logic            CLK = 1'b0;
  logic            nRESET;
  logic            TICK;
  logic [CH*CW-1:0] LV;
  logic [CH-1:0]   LOAD, SET_RUN, CLR_RUN, CLR_FLAG, ONESHOT, IRQ_EN;
  logic [CH-1:0]   RUN, OVF, OVF_FLAG;
  logic            nIRQ;
`ifdef YM_TIMER_CSM_EN
  logic            CSM_MODE;
  logic            CSM_KEYON;
`endif

  ym_timer_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .nRESET(nRESET), .TICK_144(TICK), .LOAD_VALUE(LV), .LOAD(LOAD),
    .SET_RUN(SET_RUN), .CLR_RUN(CLR_RUN), .CLR_FLAG(CLR_FLAG), .ONESHOT(ONESHOT),
    .IRQ_EN(IRQ_EN), .RUN(RUN), .OVF(OVF), .OVF_FLAG(OVF_FLAG),
`ifdef YM_TIMER_CSM_EN
    .CSM_MODE(CSM_MODE), .CSM_KEYON(CSM_KEYON),
`endif
    .nIRQ(nIRQ)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ticks remaining until the next overflow, from the period formula.
  int m_left [CH];
  bit m_run  [CH];
  bit m_ovf  [CH];
  bit m_flag [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_left[c] = CNT_N * PRE_N;
      m_run[c]  = 0;
      m_ovf[c]  = 0;
      m_flag[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int lv;
      bit ov;
      lv = int'(LV[c*CW +: CW]);
      ov = 0;
      if (LOAD[c]) begin
        m_left[c] = (CNT_N - lv) * PRE_N;
      end else if (TICK && m_run[c]) begin
        if (m_left[c] == 1) begin
          ov = 1;
          m_left[c] = (CNT_N - lv) * PRE_N;
        end else begin
          m_left[c] = m_left[c] - 1;
        end
      end
      if (CLR_RUN[c]) m_run[c] = 0;
      else if (LOAD[c] || SET_RUN[c]) m_run[c] = 1;
      else if (ov && ONESHOT[c]) m_run[c] = 0;
      m_ovf[c] = ov;
      if (ov) m_flag[c] = 1;
      else if (CLR_FLAG[c]) m_flag[c] = 0;
    end
  endtask

  // driver tasks
  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_strobes();
    LOAD = '0; SET_RUN = '0; CLR_RUN = '0; CLR_FLAG = '0; TICK = 1'b0;
  endtask

  task automatic do_reset();
    clear_strobes();
    ONESHOT = '0;
    IRQ_EN  = 2'b11;
    LV      = '0;
    nRESET  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    nRESET = 1'b1;
  endtask

  typedef struct {
    logic [1:0] load;
    logic [1:0] set_run;
    logic [1:0] clr_run;
    logic [1:0] exp_run;
  } vec_t;

  vec_t vecs [8];

  initial begin
    nRESET = 1'b0;
`ifdef YM_TIMER_CSM_EN
    CSM_MODE = 1'b0;
`endif
    do_reset();
    chk("reset_run", RUN, 2'b00);
    chk("reset_ovf", OVF, 2'b00);
    chk("reset_flag", OVF_FLAG, 2'b00);
    chk("reset_nirq", nIRQ, 1'b1);

    // Run-state priority table, no ticks.
    vecs[0] = '{2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1] = '{2'b01, 2'b00, 2'b00, 2'b01};
    vecs[2] = '{2'b00, 2'b10, 2'b00, 2'b11};
    vecs[3] = '{2'b00, 2'b00, 2'b01, 2'b10};
    vecs[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    vecs[5] = '{2'b00, 2'b00, 2'b11, 2'b00};
    vecs[6] = '{2'b00, 2'b11, 2'b00, 2'b11};
    vecs[7] = '{2'b00, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 8; i++) begin
      LOAD = vecs[i].load; SET_RUN = vecs[i].set_run; CLR_RUN = vecs[i].clr_run;
      step();
      chk($sformatf("vec%0d_run", i), RUN, vecs[i].exp_run);
      chk($sformatf("vec%0d_ovf", i), OVF, 2'b00);
    end

    // Period, one-CLK pulse, flag race and re-clear on ch0 with L=0x3FF.
    do_reset();
`ifdef YM_TIMER_CSM_EN
    CSM_MODE = 1'b1;
`endif
    LV[0 +: CW] = 10'h3FF;
    LOAD = 2'b01;
    step();
    LOAD = 2'b00;
    chk("period_run", RUN, 2'b01);
    TICK = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      CLR_FLAG = (k == 32 || k == 33) ? 2'b01 : 2'b00;
      step();
      chk($sformatf("period_ovf_t%0d", k), OVF, {1'b0, (k % 16) == 0});
      chk($sformatf("period_flag_t%0d", k), OVF_FLAG[0], (k >= 16 && k < 33) || k >= 48);
      chk($sformatf("period_nirq_t%0d", k), nIRQ, !((k >= 16 && k < 33) || k >= 48));
`ifdef YM_TIMER_CSM_EN
      chk($sformatf("csm_keyon_t%0d", k), CSM_KEYON, (k % 16) == 0);
`endif
    end
    clear_strobes();

    // One-shot on ch1 with L=0x3FE: single overflow at tick 32, then resume from reloaded state.
    do_reset();
    ONESHOT = 2'b10;
    LV[CW +: CW] = 10'h3FE;
    LOAD = 2'b10;
    step();
    LOAD = 2'b00;
    TICK = 1'b1;
    for (int k = 1; k <= 132; k++) begin
      step();
      chk($sformatf("oneshot_ovf_t%0d", k), OVF[1], k == 32);
      chk($sformatf("oneshot_run_t%0d", k), RUN[1], k < 32);
    end
    TICK = 1'b0;
    SET_RUN = 2'b10;
    step();
    SET_RUN = 2'b00;
    TICK = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("oneshot_resume_ovf_t%0d", k), OVF[1], k == 32);
    end
    clear_strobes();

    // IRQ masking with simultaneous overflows on both channels.
    do_reset();
`ifdef YM_TIMER_CSM_EN
    CSM_MODE = 1'b0;
`endif
    IRQ_EN = 2'b00;
    LV = {10'h3FF, 10'h3FF};
    LOAD = 2'b11;
    step();
    LOAD = 2'b00;
    TICK = 1'b1;
    repeat (15) step();
    chk("irq_pre_ovf", OVF, 2'b00);
    step();
    chk("irq_both_ovf", OVF, 2'b11);
`ifdef YM_TIMER_CSM_EN
    chk("csm_off_keyon", CSM_KEYON, 1'b0);
`endif
    TICK = 1'b0;
    step();
    chk("irq_ovf_width", OVF, 2'b00);
    chk("irq_flags", OVF_FLAG, 2'b11);
    chk("irq_masked", nIRQ, 1'b1);
    IRQ_EN = 2'b10;
    #1;
    chk("irq_unmask", nIRQ, 1'b0);
    chk("irq_mask_keeps_flags", OVF_FLAG, 2'b11);
    CLR_FLAG = 2'b10;
    step();
    CLR_FLAG = 2'b00;
    chk("irq_clr_flag", OVF_FLAG, 2'b01);
    chk("irq_after_clr", nIRQ, 1'b1);

    // Stop after 5 ticks, 20 ignored ticks, resume: overflow 11 ticks later.
    do_reset();
    LV[0 +: CW] = 10'h3FF;
    LOAD = 2'b01;
    step();
    LOAD = 2'b00;
    TICK = 1'b1;
    repeat (5) step();
    TICK = 1'b0;
    CLR_RUN = 2'b01;
    step();
    CLR_RUN = 2'b00;
    chk("stop_run", RUN[0], 1'b0);
    TICK = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("stop_idle_ovf_t%0d", k), OVF[0], 1'b0);
    end
    TICK = 1'b0;
    SET_RUN = 2'b01;
    step();
    SET_RUN = 2'b00;
    chk("resume_run", RUN[0], 1'b1);
    TICK = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("resume_ovf_t%0d", k), OVF[0], k == 11);
    end

    // Asynchronous reset mid-count with a flag set, then a normal load.
    step();
    step();
    chk("prereset_flag", OVF_FLAG[0], 1'b1);
    @(negedge CLK);
    #2;
    nRESET = 1'b0;
    #1;
    chk("async_rst_run", RUN, 2'b00);
    chk("async_rst_flag", OVF_FLAG, 2'b00);
    chk("async_rst_ovf", OVF, 2'b00);
    chk("async_rst_nirq", nIRQ, 1'b1);
    model_reset();
    @(posedge CLK);
    #1;
    nRESET = 1'b1;
    LOAD = 2'b01;
    TICK = 1'b1;
    step();
    LOAD = 2'b00;
    chk("post_rst_load_run", RUN, 2'b01);
    chk("post_rst_load_ovf", OVF, 2'b00);
    clear_strobes();

    // Randomized run against the countdown model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      TICK = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) LV[c*CW +: CW] = 10'h3F0 + 10'($urandom_range(0, 15));
        LOAD[c]     = ($urandom_range(0, 63) == 0);
        SET_RUN[c]  = ($urandom_range(0, 15) == 0);
        CLR_RUN[c]  = ($urandom_range(0, 63) == 0);
        CLR_FLAG[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) ONESHOT[c] = ~ONESHOT[c];
      end
      IRQ_EN = 2'($urandom_range(0, 3));
      step();
      chk($sformatf("rand%0d_run", n), RUN, {m_run[1], m_run[0]});
      chk($sformatf("rand%0d_ovf", n), OVF, {m_ovf[1], m_ovf[0]});
      chk($sformatf("rand%0d_flag", n), OVF_FLAG, {m_flag[1], m_flag[0]});
      chk($sformatf("rand%0d_nirq", n), nIRQ,
          !((m_flag[0] && IRQ_EN[0]) || (m_flag[1] && IRQ_EN[1])));
    end
    clear_strobes();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
